idu: RTL and testbench
======================

IDU -- requirements
Module: idu

Interface
- REQ-001 SHALL have parameter XLEN, default 32, giving the data path width.
- REQ-002 SHALL have parameter ALUC_W, default 4, giving the ALU opcode width; codes: ADD=0, ADD_JALR=1.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
- REQ-005 SHALL have port in_valid, input, 1, meaning inst and pc are valid.
- REQ-006 SHALL have port in_ready, output, 1, meaning the stage accepts a new instruction.
- REQ-007 SHALL have port inst, input, 32, the instruction word.
- REQ-008 SHALL have port pc, input, XLEN, the instruction address.
- REQ-009 SHALL have port wb_en, input, 1, the register-file write enable.
- REQ-010 SHALL have port wb_addr, input, 5, the register-file write index.
- REQ-011 SHALL have port wb_data, input, XLEN, the register-file write data.
- REQ-012 SHALL have port out_valid, output, 1, meaning the decoded bundle is valid.
- REQ-013 SHALL have port out_ready, input, 1, meaning the downstream ALU stage consumes the bundle.
- REQ-014 SHALL have ports aluc (ALUC_W), num1 (XLEN), num2 (XLEN), all outputs, carrying the ALU operands.
- REQ-015 SHALL have outputs rd (5), rd_wen (1), is_jump (1), link (XLEN), pc_out (XLEN), ebreak (1), illegal (1).

Function
- REQ-016 Handshake: transfer in when in_valid&&in_ready; out when out_valid&&out_ready; in_ready = (state==EMPTY) || (state==FULL && out_ready).
- REQ-017 State machine EMPTY, FULL, HALT. EMPTY->FULL on input transfer. FULL->FULL on simultaneous output and input transfer (bundle replaced, zero bubble). FULL->EMPTY on output transfer without input. FULL->HALT on output transfer of a bundle with ebreak=1.
- REQ-018 HALT: in_ready=0 and out_valid=0; leave only by rst.
- REQ-019 Latency: bundle registered, so out_valid rises the cycle after acceptance; the bundle holds stable while out_valid && !out_ready.
- REQ-020 Register file: 32 x XLEN; x0 reads 0 and ignores writes; write happens when wb_en, in any state.
- REQ-021 Decode table. The num2 immediates are sign-extended to XLEN.
  - LUI: num1=0, num2=imm_u, aluc=ADD, rd_wen=1.
  - AUIPC: num1=pc, num2=imm_u, aluc=ADD, rd_wen=1.
  - ADDI: num1=rs1, num2=imm_i, aluc=ADD, rd_wen=1.
  - ADD (funct7=0, funct3=0): num1=rs1, num2=rs2, aluc=ADD, rd_wen=1.
  - JAL: num1=pc, num2=imm_j, aluc=ADD, is_jump=1, rd_wen=1.
  - JALR (funct3=0): num1=rs1, num2=imm_i, aluc=ADD_JALR, is_jump=1, rd_wen=1.
  - EBREAK (0x00100073): ebreak=1, rd_wen=0.
- REQ-022 link SHALL equal pc+4, computed modulo 2^XLEN, for every instruction.
- REQ-023 Any encoding outside REQ-021 SHALL set illegal=1, rd_wen=0, is_jump=0 and aluc=ADD; it SHALL still be passed downstream.
- REQ-024 rd_wen SHALL be forced to 0 when rd==0.
- REQ-025 Operands SHALL be sampled at the acceptance edge; a later register write SHALL NOT alter a held bundle.

Reset
- REQ-026 When rst is high at a clock edge:
  - state=EMPTY, out_valid=0;
  - all bundle outputs (aluc, num1, num2, rd, rd_wen, is_jump, link, pc_out, ebreak, illegal) = 0;
  - all 32 registers = 0.
- REQ-027 rst SHALL override simultaneous input transfer, output transfer and wb_en; a held bundle is discarded.

Configuration
- REQ-028 Macro IDU_WB_BYPASS_EN controls register-write bypassing.
  - Defined: a same-cycle write (wb_en, wb_addr==rs!=0) SHALL supply wb_data as the operand of the instruction accepted that cycle.
  - Undefined: the pre-write register value SHALL be used.

Verification
- REQ-029 Reset, then ADDI x1,x0,5 (0x00500093) with pc=0x80000000 -> next cycle out_valid=1, num1=0, num2=5, aluc=0, rd=1, rd_wen=1, link=0x80000004.
- REQ-030 JALR x0,0(x1) with x1=0x80000011 -> aluc=1, num1=0x80000011, num2=0, is_jump=1, rd_wen=0.
- REQ-031 out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0; out_ready=1 -> back-to-back transfers, one per cycle, no bubble.
- REQ-032 wb_en=1, wb_addr=2, wb_data=0x1234 in the same cycle ADD x3,x2,x0 is accepted (x2 previously 0) -> num1=0x1234 with IDU_WB_BYPASS_EN, num1=0 without.
- REQ-033 EBREAK accepted and consumed -> state HALT, in_ready=0 and out_valid=0 thereafter; rst -> EMPTY, in_ready=1.
- REQ-034 inst=0xFFFFFFFF -> illegal=1, rd_wen=0; wb_en to x0 with 0xDEAD -> subsequent ADDI x1,x0,0 gives num1=0.

Source files
------------

// File: rtl/idu.sv
// idu -- instruction decode stage.
// Decodes one RV32 instruction per accepted handshake into an ALU operand
// bundle, reads a 32-entry register file and holds the bundle in a single
// output register with zero-bubble replacement. After an EBREAK bundle is
// consumed the stage halts until reset.
// Optional feature macro: IDU_WB_BYPASS_EN (same-cycle write-back bypass into
// the operands of the instruction accepted in that cycle).
module idu #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALUC_W-1:0] aluc,
  output logic [XLEN-1:0]   num1,
  output logic [XLEN-1:0]   num2,
  output logic [4:0]        rd,
  output logic              rd_wen,
  output logic              is_jump,
  output logic [XLEN-1:0]   link,
  output logic [XLEN-1:0]   pc_out,
  output logic              ebreak,
  output logic              illegal
);

  localparam logic [ALUC_W-1:0] ALUC_ADD      = ALUC_W'(0);
  localparam logic [ALUC_W-1:0] ALUC_ADD_JALR = ALUC_W'(1);

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] INST_EBRK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   load;

  logic [XLEN-1:0] regs [32];

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd_field;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign rd_field = inst[11:7];

  // Sign-extended immediates
  logic signed [11:0] imm_i_raw;
  logic signed [31:0] imm_u_raw;
  logic signed [20:0] imm_j_raw;
  logic [XLEN-1:0]    imm_i, imm_u, imm_j;

  assign imm_i_raw = inst[31:20];
  assign imm_u_raw = {inst[31:12], 12'b0};
  assign imm_j_raw = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_i     = XLEN'(imm_i_raw);
  assign imm_u     = XLEN'(imm_u_raw);
  assign imm_j     = XLEN'(imm_j_raw);

  // Register file: x0 is hardwired to zero, reset clears every entry and
  // reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Operand read, optionally forwarding a write landing in the same cycle
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) begin
      rs1_val = regs[rs1];
`ifdef IDU_WB_BYPASS_EN
      if (wb_en && (wb_addr == rs1)) rs1_val = wb_data;
`endif
    end
    if (rs2 != 5'd0) begin
      rs2_val = regs[rs2];
`ifdef IDU_WB_BYPASS_EN
      if (wb_en && (wb_addr == rs2)) rs2_val = wb_data;
`endif
    end
  end

  // Decode table; anything unmatched is flagged illegal with a neutral bundle
  logic [ALUC_W-1:0] dec_aluc;
  logic [XLEN-1:0]   dec_num1, dec_num2;
  logic              dec_writes, dec_is_jump, dec_ebreak, dec_illegal;

  always_comb begin
    dec_aluc    = ALUC_ADD;
    dec_num1    = '0;
    dec_num2    = '0;
    dec_writes  = 1'b0;
    dec_is_jump = 1'b0;
    dec_ebreak  = 1'b0;
    dec_illegal = 1'b0;
    if (inst == INST_EBRK) begin
      dec_ebreak = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          dec_num2   = imm_u;
          dec_writes = 1'b1;
        end
        OP_AUIPC: begin
          dec_num1   = pc;
          dec_num2   = imm_u;
          dec_writes = 1'b1;
        end
        OP_IMM: begin
          if (funct3 == 3'b000) begin
            dec_num1   = rs1_val;
            dec_num2   = imm_i;
            dec_writes = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_REG: begin
          if ((funct3 == 3'b000) && (funct7 == 7'b0)) begin
            dec_num1   = rs1_val;
            dec_num2   = rs2_val;
            dec_writes = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_JAL: begin
          dec_num1    = pc;
          dec_num2    = imm_j;
          dec_is_jump = 1'b1;
          dec_writes  = 1'b1;
        end
        OP_JALR: begin
          if (funct3 == 3'b000) begin
            dec_aluc    = ALUC_ADD_JALR;
            dec_num1    = rs1_val;
            dec_num2    = imm_i;
            dec_is_jump = 1'b1;
            dec_writes  = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Stage state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_EMPTY;
    else     state_reg <= state_next;
  end

  // Handshake and next-state logic. When an EBREAK bundle leaves, any
  // instruction offered in that same cycle is dropped because the stage halts.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_FULL;
      end
      S_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (ebreak)        state_next = S_HALT;
          else if (in_valid) state_next = S_FULL;
          else               state_next = S_EMPTY;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  assign load = in_valid && in_ready && (state_next == S_FULL);

  // Output bundle register, captured at the acceptance edge
  always_ff @(posedge clk) begin
    if (rst) begin
      aluc    <= '0;
      num1    <= '0;
      num2    <= '0;
      rd      <= '0;
      rd_wen  <= 1'b0;
      is_jump <= 1'b0;
      link    <= '0;
      pc_out  <= '0;
      ebreak  <= 1'b0;
      illegal <= 1'b0;
    end else if (load) begin
      aluc    <= dec_aluc;
      num1    <= dec_num1;
      num2    <= dec_num2;
      rd      <= rd_field;
      rd_wen  <= dec_writes && (rd_field != 5'd0);
      is_jump <= dec_is_jump;
      link    <= pc + XLEN'(4);
      pc_out  <= pc;
      ebreak  <= dec_ebreak;
      illegal <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_idu.sv
// tb_idu -- self-checking bench for idu (default XLEN=32, ALUC_W=4).
// A behavioural model (instruction-level decode, register array, stage
// occupancy flags) predicts every output; directed scenarios plus a random
// stream are compared against it cycle by cycle.
module tb_idu;

  typedef struct packed {
    logic [3:0]  aluc;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_jump;
    logic [31:0] link;
    logic [31:0] pc_out;
    logic        ebreak;
    logic        illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  aluc;
  logic [31:0] num1, num2, link, pc_out;
  logic [4:0]  rd;
  logic        rd_wen, is_jump, ebreak, illegal;

  bundle_t dut_b;
  assign dut_b = {aluc, num1, num2, rd, rd_wen, is_jump, link, pc_out, ebreak, illegal};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [31:0] m_regs [32];
  logic        m_full = 1'b0;
  logic        m_halt = 1'b0;
  bundle_t     m_b    = '0;

  always #5 clk = ~clk;

  idu #(.XLEN(32), .ALUC_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .aluc(aluc), .num1(num1),
    .num2(num2), .rd(rd), .rd_wen(rd_wen), .is_jump(is_jump), .link(link),
    .pc_out(pc_out), .ebreak(ebreak), .illegal(illegal)
  );

  // Operand value as seen by an instruction accepted this cycle
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef IDU_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  // Instruction-level reference decode
  function automatic bundle_t m_decode(input logic [31:0] i, input logic [31:0] p);
    bundle_t b;
    logic [31:0] imm_i, imm_u, imm_j, jbits;
    logic legal;
    b = '0;
    b.pc_out = p;
    b.link   = p + 32'd4;
    b.rd     = i[11:7];
    imm_i = 32'($signed(i) >>> 20);
    imm_u = i & 32'hFFFF_F000;
    jbits = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0};
    imm_j = 32'($signed(jbits) >>> 11);
    legal = 1'b1;
    if (i == 32'h0010_0073) begin
      b.ebreak = 1'b1;
      legal = 1'b0;
    end else if (i[6:0] == 7'h37) begin
      b.num2 = imm_u;
    end else if (i[6:0] == 7'h17) begin
      b.num1 = p; b.num2 = imm_u;
    end else if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin
      b.num1 = m_read(i[19:15]); b.num2 = imm_i;
    end else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd0) begin
      b.num1 = m_read(i[19:15]); b.num2 = m_read(i[24:20]);
    end else if (i[6:0] == 7'h6F) begin
      b.num1 = p; b.num2 = imm_j; b.is_jump = 1'b1;
    end else if (i[6:0] == 7'h67 && i[14:12] == 3'd0) begin
      b.num1 = m_read(i[19:15]); b.num2 = imm_i; b.is_jump = 1'b1; b.aluc = 4'd1;
    end else begin
      b.illegal = 1'b1;
      legal = 1'b0;
    end
    b.rd_wen = legal && (b.rd != 5'd0);
    return b;
  endfunction

  // Hide fields the decode table leaves unspecified for EBREAK / illegal
  function automatic bundle_t masked(input bundle_t b, input logic hide);
    bundle_t r;
    r = b;
    if (hide) begin
      r.num1 = '0; r.num2 = '0; r.rd = '0;
    end
    return r;
  endfunction

  function automatic logic exp_in_ready();
    return !m_halt && (!m_full || out_ready);
  endfunction

  function automatic logic exp_out_valid();
    return m_full && !m_halt;
  endfunction

  // Advance the model with the currently driven inputs, then one clock
  task automatic tick();
    bundle_t nb;
    logic acc, cons;
    if (rst) begin
      m_full = 1'b0; m_halt = 1'b0; m_b = '0;
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    end else begin
      acc  = in_valid && exp_in_ready();
      cons = exp_out_valid() && out_ready;
      nb   = m_decode(inst, pc);
      if (cons && m_b.ebreak) begin
        m_halt = 1'b1; m_full = 1'b0;
      end else if (acc) begin
        m_full = 1'b1; m_b = nb;
      end else if (cons) begin
        m_full = 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // reset held against input, output and write-back activity
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    inst = 32'h0050_0293; pc = 32'h40;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (dut_b !== '0) begin
      n_fail++; $display("FAIL reset_bundle: got %h expected 0", dut_b);
    end
    tick();
    // ADDI x6,x5,0 must see x5 cleared
    inst = {12'd0, 5'd5, 3'd0, 5'd6, 7'h13}; pc = 32'h44; in_valid = 1'b1; #1;
    tick();
    in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b1 || num1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got valid=%b num1=%h expected 1/0", out_valid, num1);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_addi();
    do_reset();
    inst = 32'h0050_0093; pc = 32'h8000_0000; in_valid = 1'b1; #1;
    tick();
    in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b1 || num1 !== 32'h0 || num2 !== 32'h5 || aluc !== 4'd0 ||
        rd !== 5'd1 || rd_wen !== 1'b1 || link !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL addi: got v=%b n1=%h n2=%h aluc=%0d rd=%0d wen=%b link=%h expected 1/0/5/0/1/1/80000004",
               out_valid, num1, num2, aluc, rd, rd_wen, link);
    end
    // link wraps modulo 2^32
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'hFFF0_0093; pc = 32'hFFFF_FFFC; #1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    n_checks++;
    if (link !== 32'h0 || num2 !== 32'hFFFF_FFFF || pc_out !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL link_wrap: got link=%h num2=%h pc_out=%h expected 0/ffffffff/fffffffc", link, num2, pc_out);
    end
  endtask

  task automatic test_jalr();
    out_ready = 1'b1; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h8000_0011; #1;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; inst = 32'h0000_8067; pc = 32'h1000; #1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    n_checks++;
    if (aluc !== 4'd1 || num1 !== 32'h8000_0011 || num2 !== 32'h0 || is_jump !== 1'b1 || rd_wen !== 1'b0) begin
      n_fail++; $display("FAIL jalr: got aluc=%0d n1=%h n2=%h jump=%b wen=%b expected 1/80000011/0/1/0",
                         aluc, num1, num2, is_jump, rd_wen);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h0070_0093; pc = 32'h100; #1;
    tick();
    out_ready = 1'b0; inst = 32'h0090_0113; pc = 32'h104;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || num2 !== 32'h7 || pc_out !== 32'h100) begin
        n_fail++; $display("FAIL stall cyc %0d: got rdy=%b v=%b n2=%h pc=%h expected 0/1/7/100",
                           c, in_ready, out_valid, num2, pc_out);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      inst = {12'(k + 20), 5'd0, 3'd0, 5'(k + 3), 7'h13}; pc = 32'h200 + 32'(4 * k); #1;
      exp_pc = (k == 0) ? 32'h100 : 32'h200 + 32'(4 * (k - 1));
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || pc_out !== exp_pc ||
          masked(dut_b, m_b.illegal | m_b.ebreak) !== masked(m_b, m_b.illegal | m_b.ebreak)) begin
        n_fail++; $display("FAIL b2b %0d: got rdy=%b v=%b bundle=%h expected 1/1 pc=%h bundle=%h",
                           k, in_ready, out_valid, dut_b, exp_pc, m_b);
      end
      tick();
    end
    in_valid = 1'b0; tick(); out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
    in_valid = 1'b1; inst = 32'h0001_01B3; pc = 32'h300; #1;
    tick();
    wb_en = 1'b0; out_ready = 1'b1; #1;
    n_checks++;
`ifdef IDU_WB_BYPASS_EN
    if (num1 !== 32'h1234) begin
      n_fail++; $display("FAIL bypass: got num1=%h expected 1234", num1);
    end
`else
    if (num1 !== 32'h0) begin
      n_fail++; $display("FAIL no_bypass: got num1=%h expected 0", num1);
    end
`endif
    pc = 32'h304; tick();
    in_valid = 1'b0; #1;
    n_checks++;
    if (num1 !== 32'h1234 || rd !== 5'd3 || rd_wen !== 1'b1) begin
      n_fail++; $display("FAIL add_after_wb: got num1=%h rd=%0d wen=%b expected 1234/3/1", num1, rd, rd_wen);
    end
    tick(); out_ready = 1'b0;
  endtask

  task automatic test_illegal_x0();
    in_valid = 1'b1; inst = 32'hFFFF_FFFF; pc = 32'h400; #1;
    tick();
    in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_wen !== 1'b0 || is_jump !== 1'b0 ||
        aluc !== 4'd0 || link !== 32'h404) begin
      n_fail++; $display("FAIL illegal: got v=%b ill=%b wen=%b jump=%b aluc=%0d link=%h expected 1/1/0/0/0/404",
                         out_valid, illegal, rd_wen, is_jump, aluc, link);
    end
    out_ready = 1'b1; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD; #1;
    tick();
    in_valid = 1'b1; inst = 32'h0000_0093; pc = 32'h408; #1;
    tick();
    wb_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    n_checks++;
    if (num1 !== 32'h0 || illegal !== 1'b0 || rd_wen !== 1'b1) begin
      n_fail++; $display("FAIL x0_write: got num1=%h ill=%b wen=%b expected 0/0/1", num1, illegal, rd_wen);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  r_d, r_s1, r_s2;
    logic [31:0] w;
    r_d = 5'($urandom); r_s1 = 5'($urandom); r_s2 = 5'($urandom);
    w = $urandom;
    case ($urandom_range(0, 7))
      0: return {w[31:12], r_d, 7'h37};
      1: return {w[31:12], r_d, 7'h17};
      2: return {w[31:20], r_s1, 3'd0, r_d, 7'h13};
      3: return {7'd0, r_s2, r_s1, 3'd0, r_d, 7'h33};
      4: return {w[31:12], r_d, 7'h6F};
      5: return {w[31:20], r_s1, 3'd0, r_d, 7'h67};
      6: return (w == 32'h0010_0073) ? 32'h0 : w;
      default: return {w[31:25] | 7'd1, r_s2, r_s1, 3'd0, r_d, 7'h33};
    endcase
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst      = rand_inst();
      pc        = $urandom & 32'hFFFF_FFFC;
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom);
      wb_data   = $urandom;
      #1;
      n_checks++;
      if (in_ready !== exp_in_ready() || out_valid !== exp_out_valid()) begin
        n_fail++; $display("FAIL rand_hs cyc %0d: got rdy=%b v=%b expected %b/%b",
                           c, in_ready, out_valid, exp_in_ready(), exp_out_valid());
      end
      if (exp_out_valid()) begin
        n_checks++;
        if (masked(dut_b, m_b.illegal | m_b.ebreak) !== masked(m_b, m_b.illegal | m_b.ebreak)) begin
          n_fail++; $display("FAIL rand_bundle cyc %0d: got %h expected %h", c, dut_b, m_b);
        end
      end
      tick();
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_halt();
    in_valid = 1'b1; inst = 32'h0010_0073; pc = 32'h500; #1;
    tick();
    in_valid = 1'b0; #1;
    n_checks++;
    if (out_valid !== 1'b1 || ebreak !== 1'b1 || rd_wen !== 1'b0) begin
      n_fail++; $display("FAIL ebreak: got v=%b ebreak=%b wen=%b expected 1/1/0", out_valid, ebreak, rd_wen);
    end
    out_ready = 1'b1; in_valid = 1'b1; inst = 32'h0050_0093; pc = 32'h504; #1;
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt cyc %0d: got rdy=%b v=%b expected 0/0", c, in_ready, out_valid);
      end
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0; #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_exit: got rdy=%b v=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addi();
    test_jalr();
    test_back_to_back();
    test_bypass();
    test_illegal_x0();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
